// File: rtl/matmul_mac_scheduler.sv
// Unsigned Ndata x Ndata matrix product on one shared MAC: Ndata cycles per element plus >=1 emit cycle.
// Results leave on a registered valid/ready port. Accumulation pauses while a result is stalled.
module matmul_mac_scheduler #(
  parameter int Nbits = 4,
  parameter int Ndata = 4,
  localparam int CW = $clog2(Ndata)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [Ndata*Ndata*Nbits-1:0] A_in,
  input  logic [Ndata*Ndata*Nbits-1:0] B_in,
  output logic                         busy,
  output logic                         C_valid,
  input  logic                         C_ready,
  output logic [CW-1:0]                C_row,
  output logic [CW-1:0]                C_col,
  output logic [2*Nbits-1:0]           C_data,
  output logic                         done
);

  localparam int AW = 2 * Nbits;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(Ndata - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    row_q, row_d, col_q, col_d, k_q, k_d;
  logic [AW-1:0]    acc_q, acc_d, c_data_q, c_data_d;
  logic             c_valid_q, c_valid_d, busy_q, busy_d, done_q, done_d;
  logic             capture;

  logic [Nbits-1:0] a_q [Ndata][Ndata];
  logic [Nbits-1:0] b_q [Ndata][Ndata];
  logic [Nbits-1:0] a_el, b_el;
  logic [AW-1:0]    prod, acc_sum;

  // Operands are snapshotted once so the source may change freely during a run.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < Ndata; r++) begin
        for (int c = 0; c < Ndata; c++) begin
          a_q[r][c] <= A_in[(r*Ndata+c)*Nbits +: Nbits];
          b_q[r][c] <= B_in[(r*Ndata+c)*Nbits +: Nbits];
        end
      end
    end
  end

  assign a_el    = a_q[row_q][k_q];
  assign b_el    = b_q[k_q][col_q];
  assign prod    = AW'(a_el) * AW'(b_el);
  assign acc_sum = acc_q + prod;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    acc_d     = acc_q;
    c_data_d  = c_data_q;
    c_valid_d = c_valid_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = S_MAC;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == LAST) begin
          k_d       = '0;
          state_d   = S_EMIT;
          c_data_d  = acc_sum;
          c_valid_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (C_ready) begin
          c_valid_d = 1'b0;
          if (row_q == LAST && col_q == LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MAC;
            acc_d   = '0;
            k_d     = '0;
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      c_data_q  <= c_data_d;
      c_valid_q <= c_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign C_valid = c_valid_q;
  assign C_row   = row_q;
  assign C_col   = col_q;
  assign C_data  = c_data_q;
  assign done    = done_q;

endmodule

// File: tb/tb_matmul_mac_scheduler.sv
// Bench for matmul_mac_scheduler: matrix-product model plus transfer scoreboard and cycle-exact timing checks.
module tb_matmul_mac_scheduler;
  localparam int NB = 4;
  localparam int ND = 4;
  localparam int NE = ND * ND;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        C_ready = 1'b1;
  logic [63:0] A_in = '0;
  logic [63:0] B_in = '0;
  logic        busy, C_valid, done;
  logic [1:0]  C_row, C_col;
  logic [7:0]  C_data;

  matmul_mac_scheduler #(.Nbits(NB), .Ndata(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .A_in(A_in), .B_in(B_in),
    .busy(busy), .C_valid(C_valid), .C_ready(C_ready), .C_row(C_row),
    .C_col(C_col), .C_data(C_data), .done(done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_idx = 0;
  int          done_cnt = 0;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_d = '0;
  logic [1:0]  prev_r = '0;
  logic [1:0]  prev_c = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // C[r][c] straight from the definition of a matrix product, reduced mod 256.
  function automatic logic [7:0] model_c(input logic [63:0] a, input logic [63:0] b,
                                         input int r, input int c);
    int s = 0;
    for (int k = 0; k < ND; k++)
      s += int'(a[(r*ND+k)*NB +: NB]) * int'(b[(k*ND+c)*NB +: NB]);
    return 8'(s % 256);
  endfunction

  function automatic logic [63:0] build(input int kind);
    logic [63:0] m = '0;
    for (int r = 0; r < ND; r++)
      for (int c = 0; c < ND; c++) begin
        int v;
        case (kind)
          0: v = (r == c) ? 1 : 0;
          1: v = (4*r + c) % 16;
          2: v = 15;
          3: v = (r + 2*c) % 16;
          default: v = (3*r + c) % 16;
        endcase
        m[(r*ND+c)*NB +: NB] = 4'(v);
      end
    return m;
  endfunction

  // Scoreboard: every transfer in row-major order against the model; stalled outputs must hold.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(C_valid), 32'd1);
        chk("stall_data", 32'(C_data), 32'(prev_d));
        chk("stall_row", 32'(C_row), 32'(prev_r));
        chk("stall_col", 32'(C_col), 32'(prev_c));
      end
      if (C_valid && C_ready) begin
        if (exp_idx >= NE) begin
          chk("extra_transfer", 32'(exp_idx), 32'(NE - 1));
        end else begin
          chk("xfer_row", 32'(C_row), 32'(exp_idx / ND));
          chk("xfer_col", 32'(C_col), 32'(exp_idx % ND));
          chk("xfer_data", 32'(C_data), 32'(model_c(m_a, m_b, exp_idx / ND, exp_idx % ND)));
        end
        exp_idx++;
      end
      if (done) done_cnt++;
      stall_prev = C_valid && !C_ready;
      prev_d = C_data;
      prev_r = C_row;
      prev_c = C_col;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at #1 after E0, the edge that accepted start.
  task automatic start_product(input logic [63:0] a, input logic [63:0] b);
    A_in = a;
    B_in = b;
    m_a = a;
    m_b = b;
    exp_idx = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input string name, input logic [63:0] a, input logic [63:0] b,
                     input int stall, input bit disturb);
    int e = 0;
    int first_v = -1;
    int done_e = -1;
    int idle_e = -1;
    int stall_left = stall;
    C_ready = (stall == 0);
    start_product(a, b);
    while (idle_e < 0 && e < 400) begin
      if (disturb && e == 9) start = 1'b1;
      if (disturb && e == 10) begin
        start = 1'b0;
        A_in = ~a;
        B_in = ~b;
      end
      if (stall_left > 0) begin
        if (C_valid) stall_left--;
      end else begin
        C_ready = 1'b1;
      end
      if (C_valid && first_v < 0) first_v = e;
      if (done && done_e < 0) done_e = e;
      if (!busy) idle_e = e;
      tick();
      e++;
    end
    chk({name, "_first_valid_edge"}, 32'(first_v), 32'd4);
    chk({name, "_done_edge"}, 32'(done_e), 32'(80 + stall));
    chk({name, "_idle_edge"}, 32'(idle_e), 32'(81 + stall));
    chk({name, "_transfers"}, 32'(exp_idx), 32'(NE));
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    C_ready = 1'b1;
  endtask

  initial begin
    logic [63:0] id_m, b1_m, ff_m, a3_m, b4_m;
    int guard;
    id_m = build(0);
    b1_m = build(1);
    ff_m = build(2);
    a3_m = build(3);
    b4_m = build(4);

    chk("model_identity_c12", 32'(model_c(id_m, b1_m, 1, 2)), 32'd6);
    chk("model_wrap_c00", 32'(model_c(ff_m, ff_m, 0, 0)), 32'h84);
    chk("model_mixed_c00", 32'(model_c(a3_m, b4_m, 0, 0)), 32'd84);
    chk("model_mixed_c33", 32'(model_c(a3_m, b4_m, 3, 3)), 32'd210);

    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(C_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(C_data), 32'd0);
    chk("rst_row", 32'(C_row), 32'd0);
    chk("rst_col", 32'(C_col), 32'd0);
    reset = 1'b0;
    tick();

    run("identity", id_m, b1_m, 0, 1'b0);
    run("wrap", ff_m, ff_m, 0, 1'b0);
    run("mixed", a3_m, b4_m, 0, 1'b0);
    run("backpressure", id_m, b1_m, 5, 1'b0);
    run("disturb", id_m, b1_m, 0, 1'b1);

    start_product(a3_m, b4_m);
    guard = 0;
    while (!(busy && !C_valid && C_row == 2'd1 && C_col == 2'd2) && guard < 200) begin
      tick();
      guard++;
    end
    chk("midrun_reached", 32'(guard < 200), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(C_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_data", 32'(C_data), 32'd0);
    chk("midrst_row", 32'(C_row), 32'd0);
    chk("midrst_col", 32'(C_col), 32'd0);
    tick();
    chk("midrst_idle_busy", 32'(busy), 32'd0);
    run("after_reset", id_m, b1_m, 0, 1'b0);

    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy0", 32'(busy), 32'd0);
    tick();
    chk("rst_start_busy1", 32'(busy), 32'd0);
    chk("rst_start_valid", 32'(C_valid), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_mac_scheduler.md
# matmul_mac_scheduler

Sequencer that computes an unsigned Ndata×Ndata matrix product C = A·B on a single time-shared multiply-accumulate unit. Operand matrices are captured once at start. The block walks (row, col, k) through a state machine, feeding one A·B element pair per cycle into the accumulator. Each finished dot product is emitted on a valid/ready result port in row-major order. It sits between the operand source and the result sink in the matmul path and is the sequencing layer above the scalar-product MAC datapath.

## Interface
- Nbits, default 4: width of each unsigned matrix element.
- Ndata, default 4: matrix dimension and dot-product length; Ndata ≥ 2.
- CW, derived = $clog2(Ndata): width of the row/col indices.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  request a new product; accepted only in IDLE.
- A_in  in  Ndata*Ndata*Nbits  matrix A, row-major: element (r,c) at bits [(r*Ndata+c)*Nbits +: Nbits].
- B_in  in  Ndata*Ndata*Nbits  matrix B, same packing.
- busy  out  1  high whenever state ≠ IDLE.
- C_valid  out  1  result element available.
- C_ready  in  1  sink accepts the result.
- C_row  out  CW  row index of the current result.
- C_col  out  CW  column index of the current result.
- C_data  out  2*Nbits  C[row][col], modulo 2^(2*Nbits).
- done  out  1  one-cycle pulse after the final result transfer.

## Operation
- States: IDLE, MAC, EMIT, DONE.
- IDLE:
  - On start=1, capture A_in and B_in into internal registers.
  - Clear row, col, k and acc to 0; go to MAC.
- MAC, one step per cycle:
  - acc ← acc + A[row][k]·B[k][col]; k ← k+1.
  - Product is 2*Nbits wide. The sum wraps modulo 2^(2*Nbits), matching the existing MAC datapath width.
  - After the step with k = Ndata−1: go to EMIT; C_data ← final acc; C_valid ← 1.
- EMIT, hold until C_valid && C_ready:
  - C_data, C_row and C_col are stable while stalled. No accumulation occurs.
  - On transfer at (Ndata−1, Ndata−1): go to DONE; C_valid ← 0.
  - On any other transfer: advance col; at col wrap, col ← 0 and row ← row+1. Clear acc and k, deassert C_valid, return to MAC.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in MAC, EMIT and DONE.
- A_in and B_in changes after capture have no effect on the running product.
- All outputs are registered. C_valid never depends combinationally on C_ready.
- Reset, in any state including mid-product:
  - State ← IDLE.
  - busy, C_valid and done ← 0.
  - C_data, C_row, C_col, acc and k ← 0.
  - No done pulse; the partial product is discarded.
- Reset and start high in the same cycle: reset wins; start is not captured.

## Timing
- Let E0 be the edge where start is accepted. busy is high from E0.
- Each element takes Ndata MAC cycles plus at least one EMIT cycle.
- First C_valid goes high after edge E_Ndata.
- With C_ready tied high, each element occupies Ndata+1 cycles.
  - Element n (row-major, 0-based) has C_valid high after edge E(n·(Ndata+1)+Ndata) and transfers at the next edge.
- Final transfer occurs at E(Ndata²·(Ndata+1)). done is high for the following cycle; busy drops after the next edge.
  - Defaults: first C_valid after E4, final transfer at E80, done in the cycle after E80, busy low after E81.
- Every cycle C_ready is low in EMIT adds exactly one cycle of latency.

## Test plan
1. Identity: A = I; B(r,c) = (4r+c) mod 16; ready held high.
   - 16 transfers in order (0,0)…(3,3) with C_data = 4r+c.
   - Exactly one done pulse.
2. Wrap: A = B = all 0xF.
   - Every C_data = 4·225 mod 256 = 0x84.
3. Backpressure: C_ready low for 5 cycles when the first C_valid rises, then high.
   - C_valid, C_data, C_row=0 and C_col=0 are stable for all 5 cycles.
   - Transfer occurs on the first ready-high edge.
   - done arrives 5 cycles later than in scenario 1.
4. Cycle count: ready tied high.
   - First C_valid after E4.
   - done high only in the cycle after E80.
   - busy=0 after E81.
   - start pulsed at E10 and A_in/B_in changed during the run: no effect on results or timing.
5. Reset mid-run: assert reset while C_row=1, C_col=2 is being accumulated.
   - Next cycle: busy, C_valid, done, C_data, C_row, C_col all 0.
   - A fresh start then yields the complete, correct 16-element result of scenario 1.
6. Reset with start in the same cycle: the block stays IDLE; busy=0.
